sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Shares one single-ported, 1-cycle-latency SRAM between the instruction-fetch requester (IF) and the MEM-stage data requester (DM).
- DM normally has priority. A starvation counter guarantees IF forward progress.
- For DM, the block formats byte/half/word stores into active-low byte write enables and aligns/sign-extends load data by `funct3`.
- It sits between the EX/MEM pipeline register outputs, the fetch unit and the shared SRAM macro.
- Grant deassertion is the stall indication to the requesters.

## Interface
- `ADDR_W`, 14, SRAM word-address width; byte address bits `[ADDR_W+1:2]` select the word.
- `MAX_WAIT`, 4, consecutive lost IF arbitration cycles before IF is forced to win (≥1).
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low (0 = reset).
- `if_req` in 1: IF read request; held with `if_addr` stable until `if_gnt`.
- `if_addr` in 32: IF byte address; bits `[1:0]` ignored.
- `if_gnt` out 1: IF request accepted this cycle.
- `if_rvalid` out 1: `if_rdata` valid (cycle after `if_gnt`).
- `if_rdata` out 32: instruction word; 0 when `if_rvalid`=0.
- `dm_req` in 1: DM request; held with all `dm_*` inputs stable until `dm_gnt`.
- `dm_we` in 1: 1 = store, 0 = load.
- `dm_funct3` in 3: RISC-V load/store `funct3`.
- `dm_addr` in 32: DM byte address.
- `dm_wdata` in 32: store data, right-justified.
- `dm_gnt` out 1: DM request accepted this cycle.
- `dm_rvalid` out 1: `dm_rdata` valid.
- `dm_rdata` out 32: aligned/extended load data; 0 when `dm_rvalid`=0.
- `dm_misalign` out 1: 1-cycle pulse in the grant cycle of a misaligned DM access.
- `sram_cs` out 1: chip select.
- `sram_oe` out 1: output enable, 1 on reads.
- `sram_web` out 4: active-low byte write enables; bit i controls lane `[8i+7:8i]`; `4'b1111` = no write.
- `sram_a` out ADDR_W: word address.
- `sram_di` out 32: write data.
- `sram_do` in 32: read data, valid the cycle after the access edge.

## Operation
- **Arbitration** (combinational, every cycle):
  - If `dm_req` is high and `wait_cnt` != `MAX_WAIT`, DM wins.
  - Otherwise, if `if_req` is high, IF wins.
  - Otherwise idle.
  - At most one grant per cycle.
- **`wait_cnt`** (register):
  - Increments, saturating at `MAX_WAIT`, when `if_req` is high and DM wins.
  - Clears on `if_gnt` or when `if_req` is low.
- **SRAM command:** driven combinationally from the winner in the grant cycle. When idle: `cs`=0, `oe`=0, `web`=1111, `a`=0, `di`=0.
- **IF:** `cs`=1, `oe`=1, `web`=1111, `a`=`if_addr[ADDR_W+1:2]`.
- **DM store** (`dm_we`=1), with `o` = `addr[1:0]`:
  - `000` SB: `web` = ~(0001<<o); `di` = {4{wdata[7:0]}}.
  - `001` SH: `web` = o[1] ? 0011 : 1100; `di` = {2{wdata[15:0]}}.
  - `010` SW: `web`=0000; `di`=wdata.
  - Other `funct3`: granted, `cs`=0, no write.
- **DM load:** `cs`=1, `oe`=1, `web`=1111.
  - `000` LB and `100` LBU: byte lane o, sign-/zero-extended.
  - `001` LH and `101` LHU: half lane o[1], sign-/zero-extended.
  - `010` LW and others: raw word.
- **Misaligned:** half access with o[0]=1, or word access with o≠0.
  - Still granted, with `dm_misalign`=1.
  - No SRAM access (`cs`=0, `web`=1111).
  - No `rvalid` follows.
- **Response FSM**, one register per cycle holding the in-flight read. States: `IDLE`, `RESP_IF`, `RESP_DM`.
  - Next state = `RESP_IF` on an IF grant.
  - Next state = `RESP_DM` on an aligned DM load grant.
  - Next state = `IDLE` otherwise; stores, misaligned accesses and idle cycles produce no response.
  - `RESP_DM` also latches `funct3` and o.
  - Transitions are legal from any state, so back-to-back grants give back-to-back responses.
- `if_rvalid` = (state==`RESP_IF`); `dm_rvalid` = (state==`RESP_DM`). Rdata is formed combinationally from `sram_do` and the latched fields.

## Timing
- Reset (`reset`=0, async):
  - State → `IDLE`, `wait_cnt` → 0, latched `funct3`/offset → 0.
  - Immediately: `if_rvalid`=`dm_rvalid`=0, `if_rdata`=`dm_rdata`=0, `dm_misalign`=0.
  - With requests low: `gnt`=0, `sram_cs`=0, `oe`=0, `web`=1111.
  - A read in flight at reset is dropped and never answered.
- Grant-to-response latency is exactly 1 cycle. Throughput is 1 access per cycle.
- Stores complete at the grant-cycle edge.
- If both requesters are held high, IF is granted on the (`MAX_WAIT`+1)th cycle, then DM resumes.
- Grants are combinational from `req` and `wait_cnt`. There is no combinational path from `sram_do` to any grant.

## Test plan
- **Reset:** `reset`=0 mid-IF read → `if_rvalid` drops at once. After release with requests idle: `sram_web`=1111, `cs`=0.
- **IF read:** `if_req`, `if_addr`=0x0000_0104 → same cycle `if_gnt`=1, `sram_a`=0x41. Next cycle `if_rvalid`=1, `if_rdata`=`sram_do`.
- **Store lanes:** SB `addr`=0x...2, `wdata`=0x0000_00A5 → `web`=1011, `di`=0xA5A5_A5A5. SH `addr`=0x...2 → `web`=0011. SW → `web`=0000.
- **Load extend:** `sram_do`=0x80FF_7F01. LB o=3 → 0xFFFF_FF80. LBU o=3 → 0x0000_0080. LH o=2 → 0xFFFF_80FF. LHU o=0 → 0x0000_7F01.
- **Contention:** `if_req` and `dm_req` held high, `MAX_WAIT`=4 → `dm_gnt` for cycles 1–4, `if_gnt` in cycle 5, `dm_gnt` in cycle 6. `wait_cnt` then 0.
- **Misaligned:** LW `addr`=0x...6 → `dm_gnt`=1, `dm_misalign`=1, `sram_cs`=0. No `dm_rvalid` next cycle.

Source files
------------

// File: rtl/sram_port_arbiter_if.sv
// Bundle of the IF/DM requester handshakes and the shared SRAM macro pins.
// The slave modport is the arbiter's view; master is the requester/SRAM side.
interface sram_port_arbiter_if #(
  parameter int unsigned ADDR_W = 14
) ();
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [2:0]        dm_funct3;
  logic [31:0]       dm_addr;
  logic [31:0]       dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [31:0]       dm_rdata;
  logic              dm_misalign;

  logic              sram_cs;
  logic              sram_oe;
  logic [3:0]        sram_web;
  logic [ADDR_W-1:0] sram_a;
  logic [31:0]       sram_di;
  logic [31:0]       sram_do;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_funct3, dm_addr, dm_wdata, sram_do,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata, dm_misalign,
           sram_cs, sram_oe, sram_web, sram_a, sram_di
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_funct3, dm_addr, dm_wdata, sram_do,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata, dm_misalign,
           sram_cs, sram_oe, sram_web, sram_a, sram_di
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one single-ported SRAM between instruction fetch and the data stage.
// DM has priority; a wait counter forces an IF win after MAX_WAIT lost cycles.
module sram_port_arbiter #(
  parameter int unsigned ADDR_W   = 14,
  parameter int unsigned MAX_WAIT = 4
) (
  input logic                clk,
  input logic                reset,
  sram_port_arbiter_if.slave bus
);
  localparam int unsigned    CntW    = $clog2(MAX_WAIT + 1);
  localparam logic [CntW-1:0] WaitMax = CntW'(MAX_WAIT);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StRespIf = 2'd1;
  localparam logic [1:0] StRespDm = 2'd2;

  logic [CntW-1:0] wait_q, wait_d;
  logic [1:0]      state_q, state_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      off_q, off_d;

  logic       dm_win, if_win;
  logic [1:0] off;
  logic [2:0] f3;
  logic       half_acc, word_acc, misalign;

  assign off = bus.dm_addr[1:0];
  assign f3  = bus.dm_funct3;

  // Store funct3 1xx is not a legal store, so it never counts as a half access.
  assign half_acc = (f3[1:0] == 2'b01) && (!bus.dm_we || !f3[2]);
  assign word_acc = (f3 == 3'b010);
  assign misalign = (half_acc && off[0]) || (word_acc && (off != 2'b00));

  assign dm_win = bus.dm_req && (wait_q != WaitMax);
  assign if_win = bus.if_req && !dm_win;

  assign bus.if_gnt      = if_win;
  assign bus.dm_gnt      = dm_win;
  assign bus.dm_misalign = dm_win && misalign;

  always_comb begin
    wait_d = wait_q;
    if (!bus.if_req || if_win) begin
      wait_d = '0;
    end else if (dm_win && (wait_q != WaitMax)) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_comb begin
    bus.sram_cs  = 1'b0;
    bus.sram_oe  = 1'b0;
    bus.sram_web = 4'b1111;
    bus.sram_a   = '0;
    bus.sram_di  = '0;
    if (if_win) begin
      bus.sram_cs = 1'b1;
      bus.sram_oe = 1'b1;
      bus.sram_a  = bus.if_addr[ADDR_W+1:2];
    end else if (dm_win) begin
      bus.sram_a = bus.dm_addr[ADDR_W+1:2];
      if (!misalign) begin
        if (bus.dm_we) begin
          case (f3)
            3'b000: begin
              bus.sram_cs  = 1'b1;
              bus.sram_web = ~(4'b0001 << off);
              bus.sram_di  = {4{bus.dm_wdata[7:0]}};
            end
            3'b001: begin
              bus.sram_cs  = 1'b1;
              bus.sram_web = off[1] ? 4'b0011 : 4'b1100;
              bus.sram_di  = {2{bus.dm_wdata[15:0]}};
            end
            3'b010: begin
              bus.sram_cs  = 1'b1;
              bus.sram_web = 4'b0000;
              bus.sram_di  = bus.dm_wdata;
            end
            default: ;
          endcase
        end else begin
          bus.sram_cs = 1'b1;
          bus.sram_oe = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = StIdle;
    f3_d    = f3_q;
    off_d   = off_q;
    if (if_win) begin
      state_d = StRespIf;
    end else if (dm_win && !bus.dm_we && !misalign) begin
      state_d = StRespDm;
      f3_d    = f3;
      off_d   = off;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      wait_q  <= '0;
      f3_q    <= '0;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
    end
  end

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  assign rd_byte = bus.sram_do[8*off_q +: 8];
  assign rd_half = off_q[1] ? bus.sram_do[31:16] : bus.sram_do[15:0];

  assign bus.if_rvalid = (state_q == StRespIf);
  assign bus.dm_rvalid = (state_q == StRespDm);
  assign bus.if_rdata  = bus.if_rvalid ? bus.sram_do : 32'h0;

  always_comb begin
    bus.dm_rdata = 32'h0;
    if (bus.dm_rvalid) begin
      case (f3_q)
        3'b000:  bus.dm_rdata = {{24{rd_byte[7]}}, rd_byte};
        3'b100:  bus.dm_rdata = {24'h0, rd_byte};
        3'b001:  bus.dm_rdata = {{16{rd_half[15]}}, rd_half};
        3'b101:  bus.dm_rdata = {16'h0, rd_half};
        default: bus.dm_rdata = bus.sram_do;
      endcase
    end
  end

  // Only the word-address slice of each byte address reaches the SRAM.
  logic unused_addr;
  assign unused_addr = ^{bus.if_addr[1:0], bus.if_addr[31:ADDR_W+2], bus.dm_addr[31:ADDR_W+2]};
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: a vector table of single accesses plus
// hand sequences for reset, contention and back-to-back responses.
module tb_sram_port_arbiter;
  localparam int unsigned AW = 14;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sram_port_arbiter_if #(.ADDR_W(AW)) bus ();

  sram_port_arbiter #(
    .ADDR_W   (AW),
    .MAX_WAIT (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.if_req    = 1'b0;
    bus.if_addr   = 32'h0;
    bus.dm_req    = 1'b0;
    bus.dm_we     = 1'b0;
    bus.dm_funct3 = 3'b000;
    bus.dm_addr   = 32'h0;
    bus.dm_wdata  = 32'h0;
  endtask

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [2:0]  f3;
    logic [31:0] dm_addr;
    logic [31:0] wdata;
    logic [31:0] sram_do;
    logic        e_if_gnt;
    logic        e_dm_gnt;
    logic        e_mis;
    logic        e_cs;
    logic        e_oe;
    logic [3:0]  e_web;
    logic [31:0] e_a;
    logic [31:0] e_di;
    logic        e_if_rv;
    logic        e_dm_rv;
    logic [31:0] e_if_rd;
    logic [31:0] e_dm_rd;
  } vec_t;

  localparam int NVec = 17;
  vec_t vecs[NVec];

  initial begin
    //          ifr if_addr    dmr we f3      dm_addr    wdata          sram_do
    //          ifg dmg mis cs oe web      a          di             ifrv dmrv if_rd         dm_rd
    vecs[0]  = '{1, 32'h104,  0, 0, 3'b000, 32'h0,    32'h0,         32'hDEADBEEF,
                 1, 0, 0, 1, 1, 4'b1111, 32'h41,   32'h0,         1, 0, 32'hDEADBEEF, 32'h0};
    vecs[1]  = '{0, 32'h0,    1, 1, 3'b000, 32'h1002, 32'h000000A5, 32'h0,
                 0, 1, 0, 1, 0, 4'b1011, 32'h400,  32'hA5A5A5A5,  0, 0, 32'h0, 32'h0};
    vecs[2]  = '{0, 32'h0,    1, 1, 3'b001, 32'h2,    32'h1234BEEF, 32'h0,
                 0, 1, 0, 1, 0, 4'b0011, 32'h0,    32'hBEEFBEEF,  0, 0, 32'h0, 32'h0};
    vecs[3]  = '{0, 32'h0,    1, 1, 3'b001, 32'h10,   32'h0000CAFE, 32'h0,
                 0, 1, 0, 1, 0, 4'b1100, 32'h4,    32'hCAFECAFE,  0, 0, 32'h0, 32'h0};
    vecs[4]  = '{0, 32'h0,    1, 1, 3'b010, 32'h8,    32'hCAFEF00D, 32'h0,
                 0, 1, 0, 1, 0, 4'b0000, 32'h2,    32'hCAFEF00D,  0, 0, 32'h0, 32'h0};
    vecs[5]  = '{0, 32'h0,    1, 0, 3'b000, 32'h3,    32'h0,        32'h80FF7F01,
                 0, 1, 0, 1, 1, 4'b1111, 32'h0,    32'h0,         0, 1, 32'h0, 32'hFFFFFF80};
    vecs[6]  = '{0, 32'h0,    1, 0, 3'b100, 32'h13,   32'h0,        32'h80FF7F01,
                 0, 1, 0, 1, 1, 4'b1111, 32'h4,    32'h0,         0, 1, 32'h0, 32'h00000080};
    vecs[7]  = '{0, 32'h0,    1, 0, 3'b001, 32'h2,    32'h0,        32'h80FF7F01,
                 0, 1, 0, 1, 1, 4'b1111, 32'h0,    32'h0,         0, 1, 32'h0, 32'hFFFF80FF};
    vecs[8]  = '{0, 32'h0,    1, 0, 3'b101, 32'h0,    32'h0,        32'h80FF7F01,
                 0, 1, 0, 1, 1, 4'b1111, 32'h0,    32'h0,         0, 1, 32'h0, 32'h00007F01};
    vecs[9]  = '{0, 32'h0,    1, 0, 3'b010, 32'h6,    32'h0,        32'h80FF7F01,
                 0, 1, 1, 0, 0, 4'b1111, 32'h0,    32'h0,         0, 0, 32'h0, 32'h0};
    vecs[10] = '{0, 32'h0,    1, 0, 3'b010, 32'hC,    32'h0,        32'h80FF7F01,
                 0, 1, 0, 1, 1, 4'b1111, 32'h3,    32'h0,         0, 1, 32'h0, 32'h80FF7F01};
    vecs[11] = '{0, 32'h0,    1, 1, 3'b001, 32'h1,    32'h1234,     32'h0,
                 0, 1, 1, 0, 0, 4'b1111, 32'h0,    32'h0,         0, 0, 32'h0, 32'h0};
    vecs[12] = '{0, 32'h0,    1, 1, 3'b011, 32'h0,    32'h55,       32'h0,
                 0, 1, 0, 0, 0, 4'b1111, 32'h0,    32'h0,         0, 0, 32'h0, 32'h0};
    vecs[13] = '{1, 32'h200,  1, 0, 3'b010, 32'h20,   32'h0,        32'h11223344,
                 0, 1, 0, 1, 1, 4'b1111, 32'h8,    32'h0,         0, 1, 32'h0, 32'h11223344};
    vecs[14] = '{0, 32'h0,    0, 0, 3'b000, 32'h0,    32'h0,        32'h99999999,
                 0, 0, 0, 0, 0, 4'b1111, 32'h0,    32'h0,         0, 0, 32'h0, 32'h0};
    vecs[15] = '{0, 32'h0,    1, 0, 3'b000, 32'h2,    32'h0,        32'h80FF7F01,
                 0, 1, 0, 1, 1, 4'b1111, 32'h0,    32'h0,         0, 1, 32'h0, 32'hFFFFFFFF};
    vecs[16] = '{0, 32'h0,    1, 0, 3'b000, 32'h1,    32'h0,        32'h80FF7F01,
                 0, 1, 0, 1, 1, 4'b1111, 32'h0,    32'h0,         0, 1, 32'h0, 32'h0000007F};
  end

  initial begin
    bit idle;
    idle_inputs();
    bus.sram_do = 32'h0;
    reset = 1'b0;
    #12;
    chk("rst if_rvalid", bus.if_rvalid, 1'b0);
    chk("rst dm_rvalid", bus.dm_rvalid, 1'b0);
    chk("rst if_rdata", bus.if_rdata, 32'h0);
    chk("rst dm_rdata", bus.dm_rdata, 32'h0);
    chk("rst misalign", bus.dm_misalign, 1'b0);
    chk("rst gnts", {bus.if_gnt, bus.dm_gnt}, 2'b00);
    chk("rst cs/oe", {bus.sram_cs, bus.sram_oe}, 2'b00);
    chk("rst web", bus.sram_web, 4'b1111);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < NVec; i++) begin
      bus.if_req    = vecs[i].if_req;
      bus.if_addr   = vecs[i].if_addr;
      bus.dm_req    = vecs[i].dm_req;
      bus.dm_we     = vecs[i].dm_we;
      bus.dm_funct3 = vecs[i].f3;
      bus.dm_addr   = vecs[i].dm_addr;
      bus.dm_wdata  = vecs[i].wdata;
      idle = !vecs[i].e_if_gnt && !vecs[i].e_dm_gnt;
      #2;
      chk($sformatf("v%0d if_gnt", i), bus.if_gnt, vecs[i].e_if_gnt);
      chk($sformatf("v%0d dm_gnt", i), bus.dm_gnt, vecs[i].e_dm_gnt);
      chk($sformatf("v%0d misalign", i), bus.dm_misalign, vecs[i].e_mis);
      chk($sformatf("v%0d cs", i), bus.sram_cs, vecs[i].e_cs);
      chk($sformatf("v%0d web", i), bus.sram_web, vecs[i].e_web);
      if (vecs[i].e_cs || idle)
        chk($sformatf("v%0d oe", i), bus.sram_oe, vecs[i].e_oe);
      if (vecs[i].e_cs || idle)
        chk($sformatf("v%0d a", i), 32'(bus.sram_a), vecs[i].e_a);
      if ((vecs[i].e_cs && !vecs[i].e_oe) || idle)
        chk($sformatf("v%0d di", i), bus.sram_di, vecs[i].e_di);
      @(posedge clk);
      #1;
      idle_inputs();
      bus.sram_do = vecs[i].sram_do;
      #1;
      chk($sformatf("v%0d if_rvalid", i), bus.if_rvalid, vecs[i].e_if_rv);
      chk($sformatf("v%0d dm_rvalid", i), bus.dm_rvalid, vecs[i].e_dm_rv);
      chk($sformatf("v%0d if_rdata", i), bus.if_rdata, vecs[i].e_if_rd);
      chk($sformatf("v%0d dm_rdata", i), bus.dm_rdata, vecs[i].e_dm_rd);
    end

    // Contention: IF must win every fifth cycle, then DM resumes.
    @(posedge clk);
    #1;
    bus.if_req    = 1'b1;
    bus.if_addr   = 32'h40;
    bus.dm_req    = 1'b1;
    bus.dm_funct3 = 3'b010;
    for (int c = 1; c <= 10; c++) begin
      #2;
      chk($sformatf("cont c%0d if_gnt", c), bus.if_gnt, (c % 5 == 0));
      chk($sformatf("cont c%0d dm_gnt", c), bus.dm_gnt, (c % 5 != 0));
      @(posedge clk);
      #1;
    end

    // Dropping if_req for a cycle must clear the wait count.
    for (int c = 1; c <= 8; c++) begin
      bus.if_req = (c != 3);
      #2;
      chk($sformatf("clr c%0d if_gnt", c), bus.if_gnt, (c == 8));
      chk($sformatf("clr c%0d dm_gnt", c), bus.dm_gnt, (c != 8));
      @(posedge clk);
      #1;
    end
    idle_inputs();
    @(posedge clk);
    #1;

    // Back-to-back IF read then DM LBU.
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h8;
    #2;
    chk("b2b if_gnt", bus.if_gnt, 1'b1);
    @(posedge clk);
    #1;
    idle_inputs();
    bus.dm_req    = 1'b1;
    bus.dm_funct3 = 3'b100;
    bus.dm_addr   = 32'h1;
    bus.sram_do   = 32'hA1B2C3D4;
    #1;
    chk("b2b if_rvalid", bus.if_rvalid, 1'b1);
    chk("b2b if_rdata", bus.if_rdata, 32'hA1B2C3D4);
    chk("b2b dm_gnt", bus.dm_gnt, 1'b1);
    @(posedge clk);
    #1;
    idle_inputs();
    bus.sram_do = 32'h0000A500;
    #1;
    chk("b2b dm_rvalid", bus.dm_rvalid, 1'b1);
    chk("b2b dm_rdata", bus.dm_rdata, 32'h000000A5);
    chk("b2b if_rvalid off", bus.if_rvalid, 1'b0);

    // Reset during an in-flight IF read drops the response.
    @(posedge clk);
    #1;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h104;
    @(posedge clk);
    #1;
    idle_inputs();
    bus.sram_do = 32'h12345678;
    #1;
    chk("rmid if_rvalid before", bus.if_rvalid, 1'b1);
    reset = 1'b0;
    #1;
    chk("rmid if_rvalid", bus.if_rvalid, 1'b0);
    chk("rmid if_rdata", bus.if_rdata, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rmid dropped", bus.if_rvalid, 1'b0);
    chk("rmid web", bus.sram_web, 4'b1111);
    chk("rmid cs", bus.sram_cs, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
